// File: rtl/regfile_dbg_access_if.sv
// ---------------------------------------------------------------------------
// regfile_dbg_access_if
//   Debug request/response channel between the debug module (master) and
//   regfile_dbg_access (slave). Two independent valid/ready handshakes:
//     req_*  : master -> slave, one register access (read or write)
//     resp_* : slave -> master, completion with read data and error flag
//   Signals
//     req_valid  m->s  request valid
//     req_ready  s->m  request accepted when valid & ready
//     req_write  m->s  1 = write, 0 = read
//     req_addr   m->s  target register (AW bits)
//     req_wdata  m->s  write data (XLEN bits)
//     resp_valid s->m  response valid
//     resp_ready m->s  response consumed when valid & ready
//     resp_rdata s->m  read data, 0 for writes and errors
//     resp_err   s->m  1 = core did not halt in time
// ---------------------------------------------------------------------------
interface regfile_dbg_access_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/regfile_dbg_access.sv
// ---------------------------------------------------------------------------
// regfile_dbg_access
//   Debug-side initiator for the 32x32 RegisterFile. A debug request is
//   held until the core reports halted, then the block borrows the
//   RegisterFile ports for exactly one cycle (EXEC) to perform the access,
//   and returns a response. Outside EXEC the core's ports pass straight
//   through to the RegisterFile.
//
//   Ports
//     clk, rst        clock, asynchronous active-high reset
//     dbg             debug request/response channel (slave modport)
//     core_halted_i   core stopped, RegisterFile may be borrowed
//     core_wen_i      core writeback enable
//     core_rd_i       core writeback address
//     core_din_i      core writeback data
//     core_rs1_i      core read address 1
//     core_rs2_i      core read address 2
//     wen_o, rd_o, din_o, rs1_o, rs2_o   RegisterFile port drive
//     r1_i            RegisterFile read data port 1
//
//   Timing (halted read): request handshake at cycle N, WAIT at N+1,
//   EXEC at N+2, resp_valid from N+3. Without a halt the block gives up
//   after HALT_WAIT WAIT cycles and answers with resp_err=1.
// ---------------------------------------------------------------------------
module regfile_dbg_access #(
  parameter int XLEN      = 32,
  parameter int AW        = 5,
  parameter int HALT_WAIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_dbg_access_if.slave  dbg,
  input  logic                 core_halted_i,
  input  logic                 core_wen_i,
  input  logic [AW-1:0]        core_rd_i,
  input  logic [XLEN-1:0]      core_din_i,
  input  logic [AW-1:0]        core_rs1_i,
  input  logic [AW-1:0]        core_rs2_i,
  output logic                 wen_o,
  output logic [AW-1:0]        rd_o,
  output logic [XLEN-1:0]      din_o,
  output logic [AW-1:0]        rs1_o,
  output logic [AW-1:0]        rs2_o,
  input  logic [XLEN-1:0]      r1_i
);

  localparam int CW = (HALT_WAIT > 1) ? $clog2(HALT_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALT_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            write_q, write_d;
  logic [AW-1:0]   addr_q,  addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q,   err_d;
  logic            own;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    own     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dbg.req_valid) begin
          write_d = dbg.req_write;
          addr_d  = dbg.req_addr;
          wdata_d = dbg.req_wdata;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A halt seen on the last counted cycle still wins over the timeout.
        if (core_halted_i) begin
          state_d = S_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        // Completes regardless of core_halted_i: the halt protocol keeps
        // the core off the ports for this cycle.
        own     = 1'b1;
        rdata_d = write_q ? '0 : r1_i;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (dbg.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dbg.req_ready  = (state_q == S_IDLE);
  assign dbg.resp_valid = (state_q == S_RESP);
  assign dbg.resp_rdata = rdata_q;
  assign dbg.resp_err   = err_q;

  // Port mux. core_wen_i is dropped while we own the ports; a write to x0
  // is swallowed here so the response can still report success.
  assign wen_o = own ? (write_q && (addr_q != '0)) : core_wen_i;
  assign rd_o  = own ? addr_q  : core_rd_i;
  assign din_o = own ? wdata_q : core_din_i;
  assign rs1_o = own ? addr_q  : core_rs1_i;
  assign rs2_o = own ? '0      : core_rs2_i;

endmodule
